alu_exec_stage: RTL and testbench

Execute-stage controller that sits directly upstream of the 16-bit ALU and also consumes its result. It holds a small register file and accepts commands over a valid/ready handshake. It drives the ALU operand, select and mode inputs from registered operands, captures the ALU result, and writes it back to the register file. The result is also presented downstream over a valid/ready handshake.

---
 rtl/alu_exec_stage_if.sv | 61 ++++++
 rtl/alu_exec_stage.sv | 148 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
// Bus bundle for alu_exec_stage: command, load, ALU drive/return and result channels.
// With ALU_EXEC_STATUS_EN defined the result channel also carries res_zero/res_neg.
interface alu_exec_stage_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned SEL_W = 4;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [SEL_W-1:0]  cmd_select;
  logic              cmd_mode;
  logic [REG_AW-1:0] cmd_ra;
  logic [REG_AW-1:0] cmd_rb;
  logic [REG_AW-1:0] cmd_rd;
  logic              cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;

  logic              ld_valid;
  logic [REG_AW-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic [SEL_W-1:0]  alu_select;
  logic              alu_mode;
  logic [DATA_W-1:0] alu_result;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [REG_AW-1:0] res_rd;
`ifdef ALU_EXEC_STATUS_EN
  logic              res_zero;
  logic              res_neg;
`endif

  // Execute stage side
  modport slave (
    input  cmd_valid, cmd_select, cmd_mode, cmd_ra, cmd_rb, cmd_rd, cmd_imm_en, cmd_imm,
    input  ld_valid, ld_addr, ld_data,
    input  alu_result, res_ready,
    output cmd_ready, alu_in_a, alu_in_b, alu_select, alu_mode,
    output res_valid, res_data, res_rd
`ifdef ALU_EXEC_STATUS_EN
    , output res_zero, res_neg
`endif
  );

  // Environment side: command source, ALU and result sink
  modport master (
    output cmd_valid, cmd_select, cmd_mode, cmd_ra, cmd_rb, cmd_rd, cmd_imm_en, cmd_imm,
    output ld_valid, ld_addr, ld_data,
    output alu_result, res_ready,
    input  cmd_ready, alu_in_a, alu_in_b, alu_select, alu_mode,
    input  res_valid, res_data, res_rd
`ifdef ALU_EXEC_STATUS_EN
    , input res_zero, res_neg
`endif
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage controller: register file, operand registers feeding an external ALU,
// result capture/writeback and a valid/ready result channel. Macro ALU_EXEC_STATUS_EN adds zero/neg flags.
module alu_exec_stage #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_exec_stage_if.slave  bus,
  output logic [15:0]      op_count
);
  localparam int unsigned NREGS = 2 ** REG_AW;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] alu_a_q,     alu_a_d;
  logic [DATA_W-1:0] alu_b_q,     alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q,   alu_sel_d;
  logic              alu_mode_q,  alu_mode_d;
  logic [REG_AW-1:0] rd_q,        rd_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic [REG_AW-1:0] res_rd_q,    res_rd_d;
  logic              res_valid_q, res_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [CNT_W-1:0]  op_count_q,  op_count_d;
  logic              wb_en;
`ifdef ALU_EXEC_STATUS_EN
  logic              res_zero_q,  res_zero_d;
  logic              res_neg_q,   res_neg_d;
`endif

  // State and datapath registers; cmd_ready comes up asserted out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      regs_q      <= '{default: '0};
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_mode_q  <= 1'b0;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      op_count_q  <= '0;
`ifdef ALU_EXEC_STATUS_EN
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_mode_q  <= alu_mode_d;
      rd_q        <= rd_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      op_count_q  <= op_count_d;
`ifdef ALU_EXEC_STATUS_EN
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
`endif
    end
  end

  // Next state, operand latch, result capture and register-file update
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    alu_mode_d = alu_mode_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    op_count_d = op_count_q;
    wb_en      = 1'b0;
`ifdef ALU_EXEC_STATUS_EN
    res_zero_d = res_zero_q;
    res_neg_d  = res_neg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d    = regs_q[bus.cmd_ra];
          alu_b_d    = bus.cmd_imm_en ? bus.cmd_imm : regs_q[bus.cmd_rb];
          alu_sel_d  = bus.cmd_select;
          alu_mode_d = bus.cmd_mode;
          rd_d       = bus.cmd_rd;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_data_d = bus.alu_result;
        res_rd_d   = rd_q;
        wb_en      = 1'b1;
        op_count_d = op_count_q + CNT_W'(1);
`ifdef ALU_EXEC_STATUS_EN
        res_zero_d = (bus.alu_result == '0);
        res_neg_d  = bus.alu_result[DATA_W-1];
`endif
        state_d    = RESP;
      end
      RESP: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Writeback is applied after the load so it wins an address collision
    if (bus.ld_valid) regs_d[bus.ld_addr] = bus.ld_data;
    if (wb_en)        regs_d[rd_q]        = bus.alu_result;

    cmd_ready_d = (state_d == IDLE);
    res_valid_d = (state_d == RESP);
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_in_a   = alu_a_q;
  assign bus.alu_in_b   = alu_b_q;
  assign bus.alu_select = alu_sel_q;
  assign bus.alu_mode   = alu_mode_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_rd     = res_rd_q;
  assign op_count       = op_count_q;
`ifdef ALU_EXEC_STATUS_EN
  assign bus.res_zero   = res_zero_q;
  assign bus.res_neg    = res_neg_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a 74181-style 16-bit ALU stand-in (carry-in inactive).
// Flag checks are compiled in when ALU_EXEC_STATUS_EN is defined.
module tb_alu_exec_stage;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned DATA_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] op_count;
  int          n_tests = 0;
  int          n_fail  = 0;

  alu_exec_stage_if #(.REG_AW(REG_AW), .DATA_W(DATA_W)) bus ();

  alu_exec_stage #(.REG_AW(REG_AW), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // ALU stand-in: M=1 logic functions, M=0 arithmetic with no carry-in
  function automatic logic [15:0] alu_ref(input logic [3:0] s, input logic m,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [15:0] f;
    if (m) begin
      case (s)
        4'h0: f = ~a;          4'h1: f = ~(a | b);   4'h2: f = ~a & b;     4'h3: f = 16'h0000;
        4'h4: f = ~(a & b);    4'h5: f = ~b;         4'h6: f = a ^ b;      4'h7: f = a & ~b;
        4'h8: f = ~a | b;      4'h9: f = ~(a ^ b);   4'hA: f = b;          4'hB: f = a & b;
        4'hC: f = 16'hFFFF;    4'hD: f = a | ~b;     4'hE: f = a | b;      default: f = a;
      endcase
    end else begin
      case (s)
        4'h0: f = a;                       4'h1: f = a | b;
        4'h2: f = a | ~b;                  4'h3: f = 16'hFFFF;
        4'h4: f = a + (a & ~b);            4'h5: f = (a | b) + (a & ~b);
        4'h6: f = a + ~b;                  4'h7: f = (a & ~b) - 16'd1;
        4'h8: f = a + (a & b);             4'h9: f = a + b;
        4'hA: f = (a | ~b) + (a & b);      4'hB: f = (a & b) - 16'd1;
        4'hC: f = a + a;                   4'hD: f = (a | b) + a;
        4'hE: f = (a | ~b) + a;            default: f = a - 16'd1;
      endcase
    end
    return f;
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_select, bus.alu_mode, bus.alu_in_a, bus.alu_in_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [15:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  // Offer one command for a single cycle; returns at the negedge inside EXEC
  task automatic issue(input logic [3:0] sel, input logic mode, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd, input logic imm_en,
                       input logic [15:0] imm);
    bus.cmd_select = sel;
    bus.cmd_mode   = mode;
    bus.cmd_ra     = ra;
    bus.cmd_rb     = rb;
    bus.cmd_rd     = rd;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic finish_resp();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // Observe a register through operand A using F=A, writing the same value back
  task automatic read_reg(input string tag, input logic [2:0] r, input logic [15:0] exp);
    issue(4'hF, 1'b1, r, 3'd0, r, 1'b0, 16'h0000);
    chk(tag, 32'(bus.alu_in_a), 32'(exp));
    @(negedge clk);
    finish_resp();
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_select = 4'h0;
    bus.cmd_mode   = 1'b0;
    bus.cmd_ra     = 3'd0;
    bus.cmd_rb     = 3'd0;
    bus.cmd_rd     = 3'd0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = 16'h0000;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = 3'd0;
    bus.ld_data    = 16'h0000;
    bus.res_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_res_rd",    32'(bus.res_rd),    32'd0);
    chk("rst_op_count",  32'(op_count),      32'd0);
    chk("rst_alu_a",     32'(bus.alu_in_a),  32'd0);
    chk("rst_alu_b",     32'(bus.alu_in_b),  32'd0);
    chk("rst_alu_sel",   32'(bus.alu_select), 32'd0);
    chk("rst_alu_mode",  32'(bus.alu_mode),  32'd0);

    // Add from registers: r3 = r1 + r2
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    issue(4'b1001, 1'b0, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000);
    chk("add_exec_a",     32'(bus.alu_in_a),   32'h0005);
    chk("add_exec_b",     32'(bus.alu_in_b),   32'h0003);
    chk("add_exec_sel",   32'(bus.alu_select), 32'h9);
    chk("add_exec_ready", 32'(bus.cmd_ready),  32'd0);
    chk("add_exec_valid", 32'(bus.res_valid),  32'd0);
    @(negedge clk);
    chk("add_res_valid",  32'(bus.res_valid),  32'd1);
    chk("add_res_data",   32'(bus.res_data),   32'h0008);
    chk("add_res_rd",     32'(bus.res_rd),     32'd3);
    chk("add_op_count",   32'(op_count),       32'd1);
    finish_resp();
    chk("add_idle_ready", 32'(bus.cmd_ready),  32'd1);
    chk("add_idle_valid", 32'(bus.res_valid),  32'd0);
    read_reg("add_r3", 3'd3, 16'h0008);

    // XOR with immediate, then hold off the result for four cycles
    load(3'd1, 16'h00F0);
    issue(4'b0110, 1'b1, 3'd1, 3'd0, 3'd4, 1'b1, 16'h0FF0);
    chk("xor_exec_a", 32'(bus.alu_in_a), 32'h00F0);
    chk("xor_exec_b", 32'(bus.alu_in_b), 32'h0FF0);
    @(negedge clk);
    chk("xor_res_data", 32'(bus.res_data), 32'h0F00);
    chk("xor_res_rd",   32'(bus.res_rd),   32'd4);
    chk("xor_op_count", 32'(op_count),     32'd3);
`ifdef ALU_EXEC_STATUS_EN
    chk("xor_zero", 32'(bus.res_zero), 32'd0);
    chk("xor_neg",  32'(bus.res_neg),  32'd0);
`endif
    bus.cmd_select = 4'h3;
    bus.cmd_mode   = 1'b0;
    bus.cmd_ra     = 3'd2;
    bus.cmd_rd     = 3'd6;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_res_valid", 32'(bus.res_valid),  32'd1);
      chk("bp_res_data",  32'(bus.res_data),   32'h0F00);
      chk("bp_cmd_ready", 32'(bus.cmd_ready),  32'd0);
      chk("bp_alu_sel",   32'(bus.alu_select), 32'h6);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("bp_done_valid", 32'(bus.res_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_accept",  32'(bus.cmd_ready), 32'd1);
    chk("hold_alu_a",    32'(bus.alu_in_a),  32'h00F0);
    chk("hold_alu_sel",  32'(bus.alu_select), 32'h6);
    read_reg("xor_r4", 3'd4, 16'h0F00);

    // Load in the accept cycle: operand sees the old value
    load(3'd6, 16'h1111);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3'd6;
    bus.ld_data  = 16'h2222;
    issue(4'hF, 1'b1, 3'd6, 3'd0, 3'd7, 1'b0, 16'h0000);
    bus.ld_valid = 1'b0;
    chk("rbw_alu_a", 32'(bus.alu_in_a), 32'h1111);
    @(negedge clk);
    chk("rbw_res_data", 32'(bus.res_data), 32'h1111);
    finish_resp();
    read_reg("rbw_r6", 3'd6, 16'h2222);
    read_reg("rbw_r7", 3'd7, 16'h1111);

    // Load colliding with writeback to r5: writeback wins
    issue(4'b1001, 1'b0, 3'd1, 3'd2, 3'd5, 1'b0, 16'h0000);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3'd5;
    bus.ld_data  = 16'hAAAA;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    chk("col_res_data", 32'(bus.res_data), 32'h00F3);
    chk("col_op_count", 32'(op_count),     32'd8);
    finish_resp();
    read_reg("col_r5", 3'd5, 16'h00F3);

    // Counter wrap with A minus 1 on r0 = 0
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    chk("wrap_preload", 32'(op_count), 32'hFFFF);
    issue(4'b1111, 1'b0, 3'd0, 3'd0, 3'd7, 1'b0, 16'h0000);
    @(negedge clk);
    chk("wrap_res_data", 32'(bus.res_data), 32'hFFFF);
    chk("wrap_op_count", 32'(op_count),     32'h0000);
`ifdef ALU_EXEC_STATUS_EN
    chk("wrap_neg",  32'(bus.res_neg),  32'd1);
    chk("wrap_zero", 32'(bus.res_zero), 32'd0);
`endif
    finish_resp();
    read_reg("wrap_r7", 3'd7, 16'hFFFF);

    // Reset while in EXEC discards the command
    issue(4'b1001, 1'b0, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0000);
    chk("mid_exec_count", 32'(op_count), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_op_count",  32'(op_count),      32'd0);
    chk("mid_res_data",  32'(bus.res_data),  32'd0);
    chk("mid_alu_a",     32'(bus.alu_in_a),  32'd0);
    issue(4'hF, 1'b1, 3'd6, 3'd0, 3'd6, 1'b0, 16'h0000);
    chk("mid_r6", 32'(bus.alu_in_a), 32'h0000);
    @(negedge clk);
    chk("mid_r6_res", 32'(bus.res_data), 32'h0000);
`ifdef ALU_EXEC_STATUS_EN
    chk("mid_zero", 32'(bus.res_zero), 32'd1);
    chk("mid_neg",  32'(bus.res_neg),  32'd0);
`endif
    finish_resp();
    read_reg("mid_r1", 3'd1, 16'h0000);
    chk("end_op_count", 32'(op_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
